alu_result_stage: RTL

Registered, parametrised result selector sitting between the ALU function units (add, sub, and, or, …) and the write-back path. It selects one of NUM_SRC source words by opcode, registers the result, and presents it on a valid/ready handshake. A 2-entry skid buffer sustains one transfer per cycle with a registered `in_ready`. Invalid opcodes produce a zero result with an error flag, never high-impedance, and are tallied in a saturating counter.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_result_stage_skid.sv | 83 ++++++++
 rtl/alu_result_stage.sv | 72 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Opcode map, default data width and skid buffer occupancy states.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_state_e;

endpackage

// File: rtl/alu_result_stage_skid.sv
// Two-entry skid buffer: main register drives the outputs,
// skid register absorbs one word while in_ready is registered low.
module skid_buffer
  import alu_pkg::*;
#(
  parameter int W = ALU_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         acc, xfer;

  assign acc  = in_valid && in_ready_q;
  assign xfer = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          acc && xfer: main_d = in_data;
          acc && !xfer: begin
            skid_d  = in_data;
            state_d = TWO;
          end
          !acc && xfer: state_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake flags follow the next state so both leave a flop.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Result selector between the ALU units and write-back.
// Picks a source by opcode, flags bad opcodes, counts them.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int NUM_SRC   = 4,
  parameter int OP_W      = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [OP_W-1:0]          op_code,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     op_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ERR_CNT_W-1:0]     err_count
);

  logic [WIDTH-1:0]     sel_data;
  logic                 sel_err;
  logic                 accept;
  logic [WIDTH:0]       out_word;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Opcodes past the last source yield zero, never a floating value.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (op_code == OP_W'(i)) begin
        sel_data = src_data[i*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && sel_err && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  skid_buffer #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({sel_err, sel_data}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_word),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign result    = out_word[WIDTH-1:0];
  assign op_err    = out_word[WIDTH];
  assign err_count = err_cnt_q;

endmodule
